// File: rtl/counter_if_pkg.sv
// Shared defaults and types for the paired up/down counter unit.
package counter_if_pkg;

  localparam int unsigned WIDTH_DEF       = 4;
  localparam int unsigned UP_LOAD_VAL_DEF = 5;
  localparam int unsigned DN_LOAD_VAL_DEF = 10;

  typedef enum logic {CNT_UP = 1'b0, CNT_DN = 1'b1} count_dir_e;

  // All-ones value for a counter of width w (default down-counter reset value)
  function automatic int unsigned all_ones(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned DN_RESET_VAL_DEF = all_ones(WIDTH_DEF);

endpackage

// File: rtl/counter_slice.sv
// One free-running counter with synchronous load, direction set at elaboration,
// and a registered wrap pulse.
module counter_slice
  import counter_if_pkg::*;
#(
  parameter int unsigned      WIDTH    = WIDTH_DEF,
  parameter count_dir_e       DIR      = CNT_UP,
  parameter logic [WIDTH-1:0] LOAD_VAL = '0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_next_c;
  logic             at_limit_c;

  // Next count and the limit value from which the next step wraps
  always_comb begin
    count_next_c = count;
    at_limit_c   = 1'b0;
    if (DIR == CNT_UP) begin
      count_next_c = count + ONE;
      at_limit_c   = (count == '1);
    end else begin
      count_next_c = count - ONE;
      at_limit_c   = (count == '0);
    end
  end

  // Reset beats load beats count; wrap only flags a real counting step
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= RST_VAL;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= LOAD_VAL;
      wrap  <= 1'b0;
    end else begin
      count <= count_next_c;
      wrap  <= at_limit_c;
    end
  end

endmodule

// File: rtl/counter_if_unit.sv
// Up and down counters sharing reset and load, each with its own wrap pulse.
module counter_if_unit
  import counter_if_pkg::*;
#(
  parameter int unsigned WIDTH        = WIDTH_DEF,
  parameter int unsigned UP_LOAD_VAL  = UP_LOAD_VAL_DEF,
  parameter int unsigned DN_LOAD_VAL  = DN_LOAD_VAL_DEF,
  parameter int unsigned DN_RESET_VAL = all_ones(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  output logic [WIDTH-1:0] up_counter,
  output logic [WIDTH-1:0] down_counter,
  output logic             up_wrap,
  output logic             down_wrap
);

  counter_slice #(
    .WIDTH    (WIDTH),
    .DIR      (CNT_UP),
    .LOAD_VAL (WIDTH'(UP_LOAD_VAL)),
    .RST_VAL  ('0)
  ) u_up (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .count   (up_counter),
    .wrap    (up_wrap)
  );

  counter_slice #(
    .WIDTH    (WIDTH),
    .DIR      (CNT_DN),
    .LOAD_VAL (WIDTH'(DN_LOAD_VAL)),
    .RST_VAL  (WIDTH'(DN_RESET_VAL))
  ) u_dn (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .count   (down_counter),
    .wrap    (down_wrap)
  );

endmodule

// File: tb/tb_counter_if_unit.sv
// Directed scoreboard bench for counter_if_unit at default parameters.
module tb_counter_if_unit;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load;
  logic [W-1:0] up_counter;
  logic [W-1:0] down_counter;
  logic         up_wrap;
  logic         down_wrap;

  typedef struct {
    logic [W-1:0] up;
    logic [W-1:0] dn;
    logic         uw;
    logic         dw;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  counter_if_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .up_counter   (up_counter),
    .down_counter (down_counter),
    .up_wrap      (up_wrap),
    .down_wrap    (down_wrap)
  );

  always #5 clk = ~clk;

  // Apply inputs for the coming edge and queue what that edge must produce
  task automatic drive(input logic r, input logic l,
                       input logic [W-1:0] up, input logic [W-1:0] dn,
                       input logic uw, input logic dw, input string name);
    exp_t x;
    @(negedge clk);
    reset_n = r;
    load    = l;
    x.up = up; x.dn = dn; x.uw = uw; x.dw = dw; x.name = name;
    sb.push_back(x);
  endtask

  // Monitor: one queued expectation per edge, compared just after the edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (up_counter !== e.up || down_counter !== e.dn ||
          up_wrap !== e.uw || down_wrap !== e.dw) begin
        errors++;
        $display("FAIL %s: got up=%0d dn=%0d uw=%b dw=%b, want up=%0d dn=%0d uw=%b dw=%b",
                 e.name, up_counter, down_counter, up_wrap, down_wrap,
                 e.up, e.dn, e.uw, e.dw);
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    load    = 1'b0;
    repeat (2) @(posedge clk);

    // Reset with load asserted: reset wins
    drive(1'b0, 1'b1, 4'd0, 4'd15, 1'b0, 1'b0, "reset_over_load");
    // Load, then hold load
    drive(1'b1, 1'b1, 4'd5, 4'd10, 1'b0, 1'b0, "load");
    drive(1'b1, 1'b1, 4'd5, 4'd10, 1'b0, 1'b0, "load_hold");
    // Count from load values through both wraps
    drive(1'b1, 1'b0, 4'd6,  4'd9,  1'b0, 1'b0, "count1");
    drive(1'b1, 1'b0, 4'd7,  4'd8,  1'b0, 1'b0, "count2");
    drive(1'b1, 1'b0, 4'd8,  4'd7,  1'b0, 1'b0, "count3");
    drive(1'b1, 1'b0, 4'd9,  4'd6,  1'b0, 1'b0, "count4");
    drive(1'b1, 1'b0, 4'd10, 4'd5,  1'b0, 1'b0, "count5");
    drive(1'b1, 1'b0, 4'd11, 4'd4,  1'b0, 1'b0, "count6");
    drive(1'b1, 1'b0, 4'd12, 4'd3,  1'b0, 1'b0, "count7");
    drive(1'b1, 1'b0, 4'd13, 4'd2,  1'b0, 1'b0, "count8");
    drive(1'b1, 1'b0, 4'd14, 4'd1,  1'b0, 1'b0, "count9");
    drive(1'b1, 1'b0, 4'd15, 4'd0,  1'b0, 1'b0, "count10");
    drive(1'b1, 1'b0, 4'd0,  4'd15, 1'b1, 1'b1, "wrap_edge");
    drive(1'b1, 1'b0, 4'd1,  4'd14, 1'b0, 1'b0, "wrap_pulse_end");
    drive(1'b1, 1'b0, 4'd2,  4'd13, 1'b0, 1'b0, "count13");
    drive(1'b1, 1'b0, 4'd3,  4'd12, 1'b0, 1'b0, "count14");
    drive(1'b1, 1'b0, 4'd4,  4'd11, 1'b0, 1'b0, "count15");
    drive(1'b1, 1'b0, 4'd5,  4'd10, 1'b0, 1'b0, "count16");
    drive(1'b1, 1'b0, 4'd6,  4'd9,  1'b0, 1'b0, "count17");
    drive(1'b1, 1'b0, 4'd7,  4'd8,  1'b0, 1'b0, "count18");
    drive(1'b1, 1'b0, 4'd8,  4'd7,  1'b0, 1'b0, "count19");
    drive(1'b1, 1'b0, 4'd9,  4'd6,  1'b0, 1'b0, "count20");
    // Mid-count reset while up_counter shows 9
    drive(1'b0, 1'b0, 4'd0,  4'd15, 1'b0, 1'b0, "mid_reset");
    drive(1'b1, 1'b0, 4'd1,  4'd14, 1'b0, 1'b0, "resume1");
    drive(1'b1, 1'b0, 4'd2,  4'd13, 1'b0, 1'b0, "resume2");
    // Reset with load again, then count to the edge just before a wrap
    drive(1'b0, 1'b1, 4'd0,  4'd15, 1'b0, 1'b0, "reset_load2");
    for (int i = 1; i <= 15; i++)
      drive(1'b1, 1'b0, 4'(i), 4'(15 - i), 1'b0, 1'b0, "run_to_wrap");
    // Load on what would be a wrap edge: load values, no pulse
    drive(1'b1, 1'b1, 4'd5, 4'd10, 1'b0, 1'b0, "load_on_wrap");
    drive(1'b1, 1'b0, 4'd6, 4'd9,  1'b0, 1'b0, "after_load_wrap");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
